// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    DRAIN = 2'b10
  } arb_state_e;

  localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/MUX_2_to_1.sv
// Generic two-input multiplexer: y = s ? b : a.
module MUX_2_to_1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between writeback (priority) and a
// held debug/loader write; requests a pipeline stall if writeback starves it.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned REG_ADDR     = 5,
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RegWriteW,
  input  logic [REG_ADDR-1:0] WriteRegW,
  input  logic [WIDTH-1:0]    ResultW,
  input  logic                DbgValid,
  input  logic [REG_ADDR-1:0] DbgAddr,
  input  logic [WIDTH-1:0]    DbgWData,
  output logic                DbgReady,
  output logic                DbgDone,
  output logic                StallReq,
  output logic                WE3,
  output logic [REG_ADDR-1:0] A3,
  output logic [WIDTH-1:0]    WD3
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [REG_ADDR-1:0] hold_addr;
  logic [WIDTH-1:0]    hold_data;
  logic                hold_load;
  logic                commit;

  // State and wait counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Held debug request
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_addr <= '0;
      hold_data <= '0;
    end else if (hold_load) begin
      hold_addr <= DbgAddr;
      hold_data <= DbgWData;
    end
  end

  // Next state, counter and handshake decode
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hold_load  = 1'b0;
    commit     = 1'b0;
    DbgReady   = 1'b0;
    StallReq   = 1'b0;
    case (state)
      IDLE: begin
        DbgReady = RST;
        if (DbgValid && RST) begin
          hold_load  = 1'b1;
          cnt_next   = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!RegWriteW) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else if (cnt == CNT_W'(STARVE_LIMIT - 1)) begin
          state_next = DRAIN;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        StallReq = RST;
        if (!RegWriteW) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A debug write to r0 completes the handshake but never enables the port
  assign DbgDone = commit & RST;
  assign WE3     = commit ? (hold_addr != '0) : RegWriteW;

  MUX_2_to_1 #(.WIDTH(REG_ADDR)) u_mux_a3 (
    .a (WriteRegW),
    .b (hold_addr),
    .s (commit),
    .y (A3)
  );

  MUX_2_to_1 #(.WIDTH(WIDTH)) u_mux_wd3 (
    .a (ResultW),
    .b (hold_data),
    .s (commit),
    .y (WD3)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scoreboard bench for regfile_write_arbiter (default parameters).
module tb_regfile_write_arbiter;

  logic        CLK;
  logic        RST;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        DbgValid;
  logic [4:0]  DbgAddr;
  logic [31:0] DbgWData;
  logic        DbgReady;
  logic        DbgDone;
  logic        StallReq;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  typedef struct packed {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        ready;
    logic        done;
    logic        stall;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] rf [32];

  regfile_write_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .RegWriteW (RegWriteW),
    .WriteRegW (WriteRegW),
    .ResultW   (ResultW),
    .DbgValid  (DbgValid),
    .DbgAddr   (DbgAddr),
    .DbgWData  (DbgWData),
    .DbgReady  (DbgReady),
    .DbgDone   (DbgDone),
    .StallReq  (StallReq),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Register file image built from what the port actually writes
  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(negedge CLK) if (WE3 === 1'b1) rf[A3] = WD3;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One cycle: drive inputs, queue expected port/handshake values, compare mid-cycle
  task automatic step(input string tag, input logic rst, input logic rw,
                      input logic [4:0] wreg, input logic [31:0] res,
                      input logic dv, input logic [4:0] da, input logic [31:0] dd,
                      input logic ewe, input logic [4:0] ea3, input logic [31:0] ewd,
                      input logic erdy, input logic edone, input logic estall);
    exp_t e;
    exp_t obs;
    RST       = rst;
    RegWriteW = rw;
    WriteRegW = wreg;
    ResultW   = res;
    DbgValid  = dv;
    DbgAddr   = da;
    DbgWData  = dd;
    exp_q.push_back({ewe, ea3, ewd, erdy, edone, estall});
    @(negedge CLK);
    obs = {WE3, A3, WD3, DbgReady, DbgDone, StallReq};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed we=%b a3=%0d wd3=%h rdy=%b done=%b stall=%b expected we=%b a3=%0d wd3=%h rdy=%b done=%b stall=%b",
               tag, obs.we, obs.a3, obs.wd3, obs.ready, obs.done, obs.stall,
               e.we, e.a3, e.wd3, e.ready, e.done, e.stall);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0;
    DbgValid = 1'b0; DbgAddr = '0; DbgWData = '0;

    //   tag            rst rw wreg res           dv da  dd            we a3  wd3           rdy dn st
    step("reset_pass",  0, 1, 9,  32'h99,        1, 5,  32'h1,        1, 9,  32'h99,        0, 0, 0);
    step("release",     1, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  32'h0,         1, 0, 0);

    // Idle accept, commit next cycle
    step("t1_accept",   1, 0, 0,  32'h0,         1, 5,  32'hDEADBEEF, 0, 0,  32'h0,         1, 0, 0);
    step("t1_commit",   1, 0, 0,  32'h0,         0, 0,  32'h0,        1, 5,  32'hDEADBEEF,  0, 1, 0);
    step("t1_idle",     1, 0, 1,  32'h5,         0, 0,  32'h0,        0, 1,  32'h5,         1, 0, 0);

    // Blocked for two cycles, then free
    step("t2_accept",   1, 0, 0,  32'h0,         1, 10, 32'hA5A5A5A5, 0, 0,  32'h0,         1, 0, 0);
    step("t2_wb0",      1, 1, 7,  32'h70,        0, 0,  32'h0,        1, 7,  32'h70,        0, 0, 0);
    step("t2_wb1",      1, 1, 7,  32'h71,        0, 0,  32'h0,        1, 7,  32'h71,        0, 0, 0);
    step("t2_commit",   1, 0, 7,  32'h72,        0, 0,  32'h0,        1, 10, 32'hA5A5A5A5,  0, 1, 0);

    // Starvation: stall after four blocked cycles
    step("t3_accept",   1, 0, 0,  32'h0,         1, 12, 32'hC0FFEE00, 0, 0,  32'h0,         1, 0, 0);
    step("t3_blk1",     1, 1, 8,  32'h81,        0, 0,  32'h0,        1, 8,  32'h81,        0, 0, 0);
    step("t3_blk2",     1, 1, 8,  32'h82,        0, 0,  32'h0,        1, 8,  32'h82,        0, 0, 0);
    step("t3_blk3",     1, 1, 8,  32'h83,        0, 0,  32'h0,        1, 8,  32'h83,        0, 0, 0);
    step("t3_blk4",     1, 1, 8,  32'h84,        0, 0,  32'h0,        1, 8,  32'h84,        0, 0, 0);
    step("t3_blk5",     1, 1, 8,  32'h85,        1, 1,  32'h1,        1, 8,  32'h85,        0, 0, 1);
    step("t3_blk6",     1, 1, 8,  32'h86,        0, 0,  32'h0,        1, 8,  32'h86,        0, 0, 1);
    step("t3_commit",   1, 0, 8,  32'h87,        0, 0,  32'h0,        1, 12, 32'hC0FFEE00,  0, 1, 1);
    step("t3_after",    1, 0, 8,  32'h88,        0, 0,  32'h0,        0, 8,  32'h88,        1, 0, 0);

    // Same address: writeback during accept, debug value lands last
    step("t4_accept",   1, 1, 3,  32'h11,        1, 3,  32'h22,       1, 3,  32'h11,        1, 0, 0);
    step("t4_commit",   1, 0, 3,  32'h33,        0, 0,  32'h0,        1, 3,  32'h22,        0, 1, 0);

    // Address 0: handshake completes, port stays disabled; writeback to r0 passes
    step("t5_accept",   1, 0, 0,  32'h0,         1, 0,  32'h55,       0, 0,  32'h0,         1, 0, 0);
    step("t5_commit",   1, 0, 4,  32'h44,        0, 0,  32'h0,        0, 0,  32'h55,        0, 1, 0);
    step("t5_wb_r0",    1, 1, 0,  32'h1234,      0, 0,  32'h0,        1, 0,  32'h1234,      1, 0, 0);

    // Reset in WAIT discards the held write
    step("t6_accept",   1, 0, 0,  32'h0,         1, 6,  32'h66,       0, 0,  32'h0,         1, 0, 0);
    step("t6_blocked",  1, 1, 2,  32'h20,        0, 0,  32'h0,        1, 2,  32'h20,        0, 0, 0);
    step("t6_reset",    0, 0, 2,  32'h21,        0, 0,  32'h0,        0, 2,  32'h21,        0, 0, 0);
    step("t6_release",  1, 0, 2,  32'h22,        0, 0,  32'h0,        0, 2,  32'h22,        1, 0, 0);
    step("t6_reaccept", 1, 0, 0,  32'h0,         1, 4,  32'h44,       0, 0,  32'h0,         1, 0, 0);
    step("t6_commit",   1, 0, 0,  32'h0,         0, 0,  32'h0,        1, 4,  32'h44,        0, 1, 0);
    step("t6_idle",     1, 0, 0,  32'h0,         0, 0,  32'h0,        0, 0,  32'h0,         1, 0, 0);

    check32("rf_r3_final",  rf[3],  32'h22);
    check32("rf_r5_final",  rf[5],  32'hDEADBEEF);
    check32("rf_r7_final",  rf[7],  32'h71);
    check32("rf_r10_final", rf[10], 32'hA5A5A5A5);
    check32("rf_r12_final", rf[12], 32'hC0FFEE00);
    check32("rf_r6_unwritten", rf[6], 32'h0);
    check32("rf_r4_final",  rf[4],  32'h44);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
